// File: rtl/sblk_row_dispatch_if.sv
// Command/issue bundle between the top controller, sblk_row and the row dispatcher.
// slave = dispatcher side, master = environment side (controller + sblk_row status).
interface sblk_row_dispatch_if #(
   parameter int N_ROW    = 12,
   parameter int WID_INST = 14
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [N_ROW-1:0]          cmd_mask;
   logic [WID_INST-1:0]       cmd_inst;
   logic [N_ROW-1:0]          status_sblk;
   logic [WID_INST*N_ROW-1:0] inst_data;
   logic [N_ROW-1:0]          inst_en;

   modport slave (
      input  cmd_valid, cmd_mask, cmd_inst, status_sblk,
      output cmd_ready, inst_data, inst_en
   );

   modport master (
      output cmd_valid, cmd_mask, cmd_inst, status_sblk,
      input  cmd_ready, inst_data, inst_en
   );
endinterface

// File: rtl/sblk_row_dispatch.sv
// Row dispatcher: latches a (mask, inst) command, waits for targeted rows idle,
// then strobes inst_en for one cycle; zero mask is a barrier waiting for all rows idle.
// Ports: clk_l, rst_n (async low), bus (slave: cmd_* in, status_sblk in,
//   inst_data/inst_en out, cmd_ready out), disp_busy, issue_cnt, barrier_cnt.
// Option SBLK_DISPATCH_PERF_EN adds stall_cnt and max_stall outputs.
module sblk_row_dispatch #(
   parameter int N_ROW    = 12,
   parameter int WID_INST = 14,
   parameter int HOLDOFF  = 2,
   parameter int WID_CNT  = 16
) (
   input  logic               clk_l,
   input  logic               rst_n,
   sblk_row_dispatch_if.slave bus,
   output logic               disp_busy,
   output logic [WID_CNT-1:0] issue_cnt,
   output logic [WID_CNT-1:0] barrier_cnt
`ifdef SBLK_DISPATCH_PERF_EN
   ,
   output logic [WID_CNT-1:0] stall_cnt,
   output logic [WID_CNT-1:0] max_stall
`endif
);
   localparam int WID_HOLD = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [WID_HOLD-1:0] HOLD_INIT = WID_HOLD'(HOLDOFF - 1);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HOLD} state_t;

   state_t                    r_state, w_state_nxt;
   logic [N_ROW-1:0]          r_mask;
   logic [WID_INST-1:0]       r_inst;
   logic [N_ROW-1:0]          r_inst_en;
   logic [WID_INST*N_ROW-1:0] r_inst_data, w_data_nxt;
   logic [WID_HOLD-1:0]       r_hold;
   logic [WID_CNT-1:0]        r_issue_cnt, r_barrier_cnt;
   logic                      w_accept, w_issue, w_barrier, w_stall;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_barrier   = 1'b0;
      w_stall     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (r_mask != '0) begin
               // only rows in the mask gate the issue
               if ((bus.status_sblk & r_mask) == '0) begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_stall = 1'b1;
               end
            end else if (bus.status_sblk == '0) begin
               w_barrier   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         S_HOLD: begin
            if (r_hold == '0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_data_nxt = '0;
      for (int i = 0; i < N_ROW; i++) begin
         if (r_mask[i]) w_data_nxt[i*WID_INST +: WID_INST] = r_inst;
      end
   end

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_mask        <= '0;
         r_inst        <= '0;
         r_inst_en     <= '0;
         r_inst_data   <= '0;
         r_hold        <= '0;
         r_issue_cnt   <= '0;
         r_barrier_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_inst_en <= w_issue ? r_mask : '0;
         if (w_accept) begin
            r_mask <= bus.cmd_mask;
            r_inst <= bus.cmd_inst;
         end
         if (w_issue) begin
            r_inst_data <= w_data_nxt;
            r_hold      <= HOLD_INIT;
            r_issue_cnt <= r_issue_cnt + 1'b1;
         end else if (r_state == S_HOLD && r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
         end
         if (w_barrier) r_barrier_cnt <= r_barrier_cnt + 1'b1;
      end
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.inst_en   = r_inst_en;
   assign bus.inst_data = r_inst_data;
   assign disp_busy     = (r_state != S_IDLE);
   assign issue_cnt     = r_issue_cnt;
   assign barrier_cnt   = r_barrier_cnt;

`ifdef SBLK_DISPATCH_PERF_EN
   logic [WID_CNT-1:0] r_stall_cnt, r_max_stall, r_cur_stall, w_cur_nxt;

   // current wait length saturates so max_stall saturates too
   assign w_cur_nxt = (&r_cur_stall) ? r_cur_stall : r_cur_stall + 1'b1;

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_max_stall <= '0;
         r_cur_stall <= '0;
      end else begin
         if (w_accept) begin
            r_cur_stall <= '0;
         end else if (w_stall) begin
            r_cur_stall <= w_cur_nxt;
            r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_cur_nxt > r_max_stall) r_max_stall <= w_cur_nxt;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign max_stall = r_max_stall;
`endif
endmodule
